jtag_command_dispatcher: RTL and testbench
==========================================

Name: jtag_command_dispatcher

Overview:
System-clock-domain consumer of the synchronized JTAG command flag, i.e. the sticky flag output by the JTAG-to-system clock synchronizer. On a new command it captures opcode, address and write data from the JTAG shadow register, which is quasi-static while the flag is set. It runs one bus read or write with a request/grant/done handshake and publishes the result for JTAG capture. It then commands the synchronizer to clear its sticky flag and re-arms for the next command.

Parameters:
DATA_WIDTH, 32, width of bus and JTAG data fields
ADDR_WIDTH, 32, width of bus address field
TIMEOUT_CYCLES, 1024, max cycles from entering REQ to bus_done before abort (>=2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_flag  input  1  synchronized sticky command flag (level)
cmd_opcode  input  2  00 NOP, 01 READ, 10 WRITE, 11 reserved
cmd_addr  input  ADDR_WIDTH  command address
cmd_wdata  input  DATA_WIDTH  command write data
flag_clear  output  1  drives the synchronizer's clear; high while waiting for cmd_flag to drop
bus_request  output  1  bus transaction request
bus_grant  input  1  arbiter grant
bus_address  output  ADDR_WIDTH  registered address
bus_write  output  1  1 write, 0 read
bus_wdata  output  DATA_WIDTH  registered write data
bus_rdata  input  DATA_WIDTH  read data, valid with bus_done
bus_done  input  1  single-cycle transaction-complete strobe
busy  output  1  high in any state except IDLE
rsp_valid  output  1  one-cycle pulse when rsp_* update
rsp_data  output  DATA_WIDTH  read data (READ OK), else 0
rsp_status  output  2  00 OK, 01 TIMEOUT, 10 BAD_OPCODE
cmd_count  output  8  completed-command counter, wraps 255->0

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset in any state returns to IDLE next edge. bus_request drops that cycle; any in-flight response is discarded.
- FSM states: IDLE, CAPTURE, REQ, XFER, RESP, WAIT_CLR.
- IDLE: if cmd_flag=1, go to CAPTURE. Level-triggered; a flag already high out of reset starts a command.
- CAPTURE (1 cycle): register cmd_addr into bus_address, cmd_wdata into bus_wdata, opcode[1] into bus_write, and the opcode internally.
  - opcode 00 -> RESP with status OK.
  - opcode 11 -> RESP with status BAD_OPCODE.
  - otherwise -> REQ, timeout counter cleared.
- REQ: bus_request=1 (registered, asserted on the first REQ cycle).
  - bus_grant=1 and bus_done=1 in the same cycle -> complete immediately (to RESP).
  - bus_grant=1 only -> XFER.
- XFER: bus_request stays 1; wait for bus_done.
- Completion: on bus_done in REQ or XFER:
  - latch bus_rdata into rsp_data if READ, else 0;
  - status OK; bus_request deasserts next cycle; go to RESP.
- Timeout: counter increments each cycle in REQ/XFER. When it equals TIMEOUT_CYCLES-1 with no bus_done, abort: bus_request=0, status TIMEOUT, rsp_data=0, go to RESP. bus_done in the same cycle as expiry wins (status OK).
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits.
- RESP (1 cycle): rsp_valid=1; rsp_status/rsp_data updated with it and held until the next RESP; cmd_count+1 mod 256 for every command including errors; go to WAIT_CLR.
- WAIT_CLR: flag_clear=1.
  - cmd_flag=0 -> flag_clear=0, go to IDLE.
  - No timeout; the block stays in WAIT_CLR while cmd_flag=1.
- Latency (NOP): flag high in IDLE at edge N -> rsp_valid high in cycle N+2 -> flag_clear high from N+3.
- bus_address/bus_write/bus_wdata are stable from CAPTURE until the next CAPTURE.

Test Plan:
- Reset with cmd_flag=0 -> all outputs 0, busy=0; hold reset 3 cycles mid-XFER -> bus_request=0 the cycle after the first reset edge, state IDLE, cmd_count unchanged.
- WRITE addr=0x0000_1000 wdata=0xDEADBEEF, grant after 2 cycles, done after 3 more -> bus_write=1, address and data match; rsp_valid once, status 00, rsp_data 0, cmd_count=1; flag_clear high until cmd_flag dropped.
- READ addr=0x20, grant and done in the same cycle with bus_rdata=0x1234_5678 -> rsp_data=0x12345678, status 00, request high exactly 1 cycle.
- READ with TIMEOUT_CYCLES=8, no grant -> bus_request high 8 cycles then low; status 01, rsp_data 0. Repeat with done on cycle 8 -> status 00.
- Opcode 11 and opcode 00 -> no bus_request; status 10 and 00 respectively; rsp_valid at N+2.
- 256 back-to-back NOPs, cmd_flag held 5 cycles into WAIT_CLR each time -> cmd_count wraps to 0; no second command starts while cmd_flag stays high in WAIT_CLR.

Source files
------------

// File: rtl/jtag_command_dispatcher.sv
// System-clock consumer of the synchronized JTAG command flag: captures the shadow
// command, runs one bus read/write with timeout, publishes the response, then clears the flag.
module jtag_command_dispatcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_flag,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  flag_clear,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_done,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic [7:0]            cmd_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CAPTURE  = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_XFER     = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;
  localparam logic [2:0] ST_WAIT_CLR = 3'd5;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_BADOP   = 2'b10;

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic [2:0]            state_q, state_d;
  logic [1:0]            opcode_q, opcode_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  flag_clear_q, flag_clear_d;
  logic                  bus_request_q, bus_request_d;
  logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
  logic                  bus_write_q, bus_write_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [7:0]            cmd_count_q, cmd_count_d;

  // Next-state, response and output computation; all outputs are registered from *_d.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    tmo_cnt_d     = tmo_cnt_q;
    bus_address_d = bus_address_q;
    bus_write_d   = bus_write_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    cmd_count_d   = cmd_count_q;
    rsp_valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_flag) state_d = ST_CAPTURE;
        else          state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        bus_address_d = cmd_addr;
        bus_wdata_d   = cmd_wdata;
        bus_write_d   = cmd_opcode[1];
        opcode_d      = cmd_opcode;
        tmo_cnt_d     = '0;
        case (cmd_opcode)
          OP_NOP: begin
            state_d      = ST_RESP;
            rsp_status_d = STAT_OK;
            rsp_data_d   = '0;
          end
          OP_RSVD: begin
            state_d      = ST_RESP;
            rsp_status_d = STAT_BADOP;
            rsp_data_d   = '0;
          end
          default: state_d = ST_REQ;
        endcase
      end
      ST_REQ, ST_XFER: begin
        tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        // A done strobe on the expiry cycle still counts as a successful transfer.
        if (bus_done) begin
          state_d      = ST_RESP;
          rsp_status_d = STAT_OK;
          if (opcode_q == OP_READ) rsp_data_d = bus_rdata;
          else                     rsp_data_d = '0;
        end else if (tmo_cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          rsp_status_d = STAT_TIMEOUT;
          rsp_data_d   = '0;
        end else if (state_q == ST_REQ && bus_grant) begin
          state_d = ST_XFER;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (cmd_flag) state_d = ST_WAIT_CLR;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RESP) begin
      rsp_valid_d = 1'b1;
      cmd_count_d = cmd_count_q + 8'd1;
    end else begin
      rsp_valid_d = 1'b0;
      cmd_count_d = cmd_count_q;
    end

    flag_clear_d  = (state_d == ST_WAIT_CLR);
    bus_request_d = (state_d == ST_REQ) || (state_d == ST_XFER);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      opcode_q      <= 2'b00;
      tmo_cnt_q     <= '0;
      flag_clear_q  <= 1'b0;
      bus_request_q <= 1'b0;
      bus_address_q <= '0;
      bus_write_q   <= 1'b0;
      bus_wdata_q   <= '0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= 2'b00;
      cmd_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      tmo_cnt_q     <= tmo_cnt_d;
      flag_clear_q  <= flag_clear_d;
      bus_request_q <= bus_request_d;
      bus_address_q <= bus_address_d;
      bus_write_q   <= bus_write_d;
      bus_wdata_q   <= bus_wdata_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      cmd_count_q   <= cmd_count_d;
    end
  end

  assign flag_clear  = flag_clear_q;
  assign bus_request = bus_request_q;
  assign bus_address = bus_address_q;
  assign bus_write   = bus_write_q;
  assign bus_wdata   = bus_wdata_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign cmd_count   = cmd_count_q;

endmodule

// File: tb/tb_jtag_command_dispatcher.sv
// Directed bench for jtag_command_dispatcher: expected responses are queued when a
// command is issued and compared when rsp_valid pulses.
module tb_jtag_command_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_flag;
  logic [1:0]  cmd_opcode;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        flag_clear;
  logic        bus_request;
  logic        bus_grant;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_done;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [7:0]  cmd_count;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
    logic [7:0]  count;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] exp_count = 8'd0;
  int         n_checks = 0;
  int         n_err = 0;

  jtag_command_dispatcher #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd_flag(cmd_flag), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .flag_clear(flag_clear),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_address(bus_address),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_done(bus_done), .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'({rsp_status, rsp_data, cmd_count}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(e.status));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("cmd_count", 64'(cmd_count), 64'(e.count));
      end
    end
  end

  // Queue the expected response, present the command, and step to REQ (or RESP).
  task automatic start_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w,
                           input logic [1:0] st, input logic [31:0] d);
    exp_count = exp_count + 8'd1;
    exp_q.push_back({st, d, exp_count});
    cmd_opcode = op;
    cmd_addr   = a;
    cmd_wdata  = w;
    cmd_flag   = 1'b1;
    tick();
    chk("busy_capture", 64'(busy), 64'd1);
    chk("rsp_valid_capture", 64'(rsp_valid), 64'd0);
    tick();
  endtask

  // Wait for flag_clear, hold cmd_flag for `hold` cycles, then drop it and expect IDLE.
  task automatic release_flag(input int hold);
    int n;
    n = 0;
    while (!flag_clear && n < 40) begin
      tick();
      n++;
    end
    chk("flag_clear_up", 64'(flag_clear), 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("flag_clear_held", 64'(flag_clear), 64'd1);
      chk("no_restart_req", 64'(bus_request), 64'd0);
    end
    cmd_flag = 1'b0;
    tick();
    chk("flag_clear_down", 64'(flag_clear), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_flag = 1'b0; cmd_opcode = 2'b00; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    bus_grant = 1'b0; bus_rdata = 32'd0; bus_done = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({flag_clear, bus_request, bus_write, busy, rsp_valid, rsp_status, cmd_count}), 64'd0);
    chk("reset_addr_data", 64'({bus_address, bus_wdata}), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 64'(busy), 64'd0);

    // Reset in the middle of a transfer discards it.
    cmd_opcode = 2'b01; cmd_addr = 32'h0000_0044; cmd_flag = 1'b1;
    tick(); tick();
    chk("midx_req", 64'(bus_request), 64'd1);
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    tick();
    chk("midx_in_xfer", 64'(bus_request), 64'd1);
    reset = 1'b1;
    tick();
    chk("midx_req_drop", 64'(bus_request), 64'd0);
    chk("midx_idle", 64'(busy), 64'd0);
    chk("midx_count", 64'(cmd_count), 64'd0);
    cmd_flag = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midx_after", 64'({busy, rsp_valid, flag_clear}), 64'd0);

    // WRITE: grant after 2 REQ cycles, done 3 cycles later.
    start_cmd(2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 32'd0);
    chk("wr_req", 64'(bus_request), 64'd1);
    chk("wr_write", 64'(bus_write), 64'd1);
    chk("wr_addr", 64'(bus_address), 64'h1000);
    chk("wr_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
    tick(); tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    tick(); tick();
    bus_rdata = 32'hFFFF_0000;
    bus_done = 1'b1;
    chk("wr_req_before_done", 64'(bus_request), 64'd1);
    tick();
    bus_done = 1'b0;
    chk("wr_req_drop", 64'(bus_request), 64'd0);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_addr_stable", 64'(bus_address), 64'h1000);
    release_flag(3);

    // READ with grant and done together.
    start_cmd(2'b01, 32'h0000_0020, 32'h0, 2'b00, 32'h1234_5678);
    chk("rd_write", 64'(bus_write), 64'd0);
    bus_grant = 1'b1; bus_done = 1'b1; bus_rdata = 32'h1234_5678;
    chk("rd_req", 64'(bus_request), 64'd1);
    tick();
    bus_grant = 1'b0; bus_done = 1'b0; bus_rdata = 32'h0;
    chk("rd_req_one_cycle", 64'(bus_request), 64'd0);
    release_flag(1);

    // READ with no grant: aborts after 8 request cycles.
    start_cmd(2'b01, 32'h0000_0030, 32'h0, 2'b01, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("to_req_high", 64'(bus_request), 64'd1);
      tick();
    end
    chk("to_req_low", 64'(bus_request), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    release_flag(1);

    // done on the 8th request cycle beats the timeout.
    start_cmd(2'b01, 32'h0000_0034, 32'h0, 2'b00, 32'hA5A5_0008);
    for (int i = 0; i < 7; i++) begin
      chk("tw_req_high", 64'(bus_request), 64'd1);
      tick();
    end
    bus_done = 1'b1; bus_rdata = 32'hA5A5_0008;
    chk("tw_req_last", 64'(bus_request), 64'd1);
    tick();
    bus_done = 1'b0; bus_rdata = 32'h0;
    chk("tw_req_low", 64'(bus_request), 64'd0);
    release_flag(1);

    // Reserved opcode and NOP: no bus traffic, response in N+2.
    start_cmd(2'b11, 32'h0000_0050, 32'h0, 2'b10, 32'd0);
    chk("bad_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bad_no_req", 64'(bus_request), 64'd0);
    tick();
    chk("bad_flag_clear", 64'(flag_clear), 64'd1);
    release_flag(1);

    start_cmd(2'b00, 32'h0000_0060, 32'h0, 2'b00, 32'd0);
    chk("nop_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("nop_no_req", 64'(bus_request), 64'd0);
    tick();
    chk("nop_flag_clear", 64'(flag_clear), 64'd1);
    chk("nop_rsp_pulse", 64'(rsp_valid), 64'd0);
    release_flag(1);

    // 256 back-to-back NOPs, flag held into WAIT_CLR: count wraps through 0.
    for (int k = 0; k < 256; k++) begin
      start_cmd(2'b00, 32'(k), 32'h0, 2'b00, 32'd0);
      chk("loop_rsp_valid", 64'(rsp_valid), 64'd1);
      release_flag(5);
    end
    chk("wrap_count", 64'(cmd_count), 64'(exp_count));

    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
